// File: rtl/fp_issue_ctrl_pkg.sv
// Shared FP wire types: execute-unit bundles, operation decode and the
// issue-controller state/entry types used by fp_issue_ctrl.
package fp_issue_ctrl_pkg;

  localparam int unsigned FP_ISSUE_TAG_W = 4;
  localparam logic [4:0]  FP_FLAG_NV     = 5'b10000;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmsub;
    logic fnmadd;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fclass;
    logic fmv_i2f;
    logic fmv_f2i;
    logic fcvt;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef enum logic [1:0] {
    FP_ISSUE_IDLE,
    FP_ISSUE_ISSUE,
    FP_ISSUE_WAIT,
    FP_ISSUE_RESP
  } fp_issue_state_type;

  typedef struct packed {
    logic [63:0]               data1;
    logic [63:0]               data2;
    logic [63:0]               data3;
    fp_operation_type          op;
    logic [1:0]                fmt;
    logic [2:0]                rm;
    logic [FP_ISSUE_TAG_W-1:0] tag;
  } fp_issue_entry_type;

endpackage

// File: rtl/fp_issue_fifo.sv
// Synchronous request FIFO of fp_issue_entry_type; DEPTH must be a power of two.
module fp_issue_fifo
  import fp_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fp_issue_entry_type wr_entry,
  input  logic               pop,
  output fp_issue_entry_type rd_entry,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  fp_issue_entry_type mem_q [DEPTH];
  fp_issue_entry_type mem_d [DEPTH];
  logic               do_push, do_pop;

  assign full     = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP request sequencer: buffers ops, issues one enable pulse per op, holds the
// tagged result until accepted. Optional watchdog: FP_ISSUE_WATCHDOG_EN.
module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TAG_W   = FP_ISSUE_TAG_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_data1,
  input  logic [63:0]      req_data2,
  input  logic [63:0]      req_data3,
  input  fp_operation_type req_op,
  input  logic [1:0]       req_fmt,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  output fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FP_ISSUE_WATCHDOG_EN
  output logic             watchdog_err,
`endif
  output logic             busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W > FP_ISSUE_TAG_W || TIMEOUT < 1)
  begin : g_param_check
    $error("fp_issue_ctrl: invalid DEPTH/TAG_W/TIMEOUT");
  end

  fp_issue_state_type state_q, state_d;
  fp_issue_entry_type op_q, op_d, wr_entry, head;
  logic [63:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

`ifdef FP_ISSUE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
  assign watchdog_err = wd_err_q;
`endif

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign rsp_valid  = (state_q == FP_ISSUE_RESP);
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_tag    = tag_q;
  assign busy       = (state_q != FP_ISSUE_IDLE) || !fifo_empty;

  always_comb begin
    wr_entry = '{data1: req_data1, data2: req_data2, data3: req_data3, op: req_op,
                 fmt: req_fmt, rm: req_rm, tag: FP_ISSUE_TAG_W'(req_tag)};
  end

  fp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .wr_entry (wr_entry),
    .pop      (fifo_pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    tag_d    = tag_q;
    fifo_pop = 1'b0;
`ifdef FP_ISSUE_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
`endif
    case (state_q)
      FP_ISSUE_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tag_d    = TAG_W'(head.tag);
          if (head.op != init_fp_operation) begin
            op_d    = head;
            state_d = FP_ISSUE_ISSUE;
          end else begin
            // Illegal (empty) op: answer invalid-operation without touching the unit.
            result_d = '0;
            flags_d  = FP_FLAG_NV;
            state_d  = FP_ISSUE_RESP;
          end
        end
      end
      FP_ISSUE_ISSUE: begin
        state_d = FP_ISSUE_WAIT;
`ifdef FP_ISSUE_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      FP_ISSUE_WAIT: begin
        if (fp_exe_o.ready) begin
          result_d = fp_exe_o.result;
          flags_d  = fp_exe_o.flags;
          state_d  = FP_ISSUE_RESP;
        end
`ifdef FP_ISSUE_WATCHDOG_EN
        else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_d == WD_W'(TIMEOUT)) begin
            result_d = '0;
            flags_d  = FP_FLAG_NV;
            wd_err_d = 1'b1;
            state_d  = FP_ISSUE_RESP;
          end
        end
`endif
      end
      FP_ISSUE_RESP: begin
        if (rsp_ready) state_d = FP_ISSUE_IDLE;
      end
      default: state_d = FP_ISSUE_IDLE;
    endcase
  end

  // Operand bundle is only presented while an op is in flight; zero otherwise.
  always_comb begin
    fp_exe_i = '0;
    if (state_q == FP_ISSUE_ISSUE || state_q == FP_ISSUE_WAIT) begin
      fp_exe_i.data1  = op_q.data1;
      fp_exe_i.data2  = op_q.data2;
      fp_exe_i.data3  = op_q.data3;
      fp_exe_i.op     = op_q.op;
      fp_exe_i.fmt    = op_q.fmt;
      fp_exe_i.rm     = op_q.rm;
      fp_exe_i.enable = (state_q == FP_ISSUE_ISSUE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= FP_ISSUE_IDLE;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
`ifdef FP_ISSUE_WATCHDOG_EN
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      tag_q    <= tag_d;
`ifdef FP_ISSUE_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
`endif
    end
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
Request sequencer directly upstream of the FPU execute unit. It buffers incoming FP operations in a small FIFO and issues them one at a time as single-cycle enable pulses on the execute input bundle. It waits for the unit's ready pulse, then holds the result with its tag until the consumer accepts it. Variable latency (pipelined FMA, iterative divide/sqrt, single-cycle sign-inject/move) is hidden behind valid/ready handshakes.

Parameters:
DEPTH, 2, request FIFO entries; power of two, >=2
TAG_W, 4, width of the caller tag carried request->response
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  FIFO not full
req_data1/req_data2/req_data3  in  64 each  operands
req_op  in  fp_operation_type  decoded operation, at most one-hot
req_fmt  in  2  format
req_rm  in  3  rounding mode
req_tag  in  TAG_W  caller tag
fp_exe_i  out  fp_exe_in_type  bundle to execute unit
fp_exe_o  in  fp_exe_out_type  bundle from execute unit
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts
rsp_result  out  64  result
rsp_flags  out  5  {NV,DZ,OF,UF,NX}
rsp_tag  out  TAG_W  tag of the completed op
busy  out  1  FSM not IDLE, or FIFO non-empty

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_result/flags/tag=0, fp_exe_i=0 (op=init_fp_operation, enable=0), busy=0.
- FIFO: push on req_valid&&req_ready; pop when IDLE dispatches. Push and pop in the same cycle are allowed when full (count unchanged). Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, FIFO non-empty, head op non-zero: pop the head into the operand register and go to ISSUE.
- IDLE, FIFO non-empty, head op all-zero (illegal): pop, load rsp_result=0, rsp_flags=5'b10000, tag, and go to RESP. Nothing is issued.
- ISSUE: drive fp_exe_i from the operand register with enable=1 for exactly this cycle, then go to WAIT. fp_exe_i data/op/fmt/rm stay stable from ISSUE until leaving WAIT. enable=0 everywhere except ISSUE.
- WAIT: on fp_exe_o.ready=1, capture result and flags, then go to RESP. Minimum issue-to-response latency is 2 cycles: ISSUE, then ready in the first WAIT cycle, then rsp_valid the next cycle.
- fp_exe_o.ready is ignored in IDLE, ISSUE and RESP. Stale pulses must not create responses.
- RESP: rsp_valid=1 with stable result/flags/tag. On rsp_ready=1, go to IDLE. A new dispatch can start the cycle after, so back-to-back throughput is one op per 4 cycles minimum.
- No second op is issued while one is outstanding.
- Reset mid-operation: in-flight op and FIFO contents are discarded. The execute unit shares the same reset.

Optional Feature:
FP_ISSUE_WATCHDOG_EN.
- Defined: a counter of width clog2(TIMEOUT+1) clears on ISSUE and increments each WAIT cycle. If it reaches TIMEOUT with no ready, go to RESP with rsp_result=64'h0, rsp_flags=5'b10000, and assert output port watchdog_err (1 bit, sticky, cleared only by reset). A ready arriving in the same cycle as the timeout wins, and no error is raised.
- Undefined: no counter, no watchdog_err port, WAIT is unbounded.

Decomposition:
- Shared FP wire package gains fp_issue_state_type (2-bit enum) and fp_issue_entry_type (data1..3, op, fmt, rm, tag). The tag width comes from a package constant, FP_ISSUE_TAG_W=4, which defaults TAG_W.
- One sub-module: fp_issue_fifo (synchronous FIFO of fp_issue_entry_type, DEPTH param, outputs full/empty). The FSM stays in fp_issue_ctrl.

Test Plan:
- FMUL with data1=3.0, data2=2.0 (double), tag=5; model returns ready 3 cycles after enable with 0x4018000000000000 -> one enable pulse, then rsp_valid with result 0x4018000000000000, flags 0, tag 5.
- Push 3 requests with DEPTH=2 and execute stalled -> req_ready=0 after two buffered plus one dispatched. Responses come out in order with tags 0,1,2. enable never asserts while WAIT or RESP.
- Request with op=0, tag=9 -> no enable. rsp_valid appears 1 cycle after dispatch with result 0, flags 5'b10000, tag 9.
- Spurious fp_exe_o.ready in IDLE, then rsp_ready held 0 for 10 cycles in RESP -> no extra response; result stable for all 10 cycles; next issue only after acceptance.
- Reset asserted during WAIT with 1 entry queued -> all outputs at reset values immediately (async). After release, busy=0 and a late ready is ignored.
- Watchdog (FP_ISSUE_WATCHDOG_EN, TIMEOUT=8): no ready -> response after 8 WAIT cycles with flags 5'b10000 and watchdog_err=1. Repeat with ready on cycle 8 -> normal result and watchdog_err stays 0.
